// File: rtl/noc_pkg.sv
// Shared router definitions: flit type codes, port indices and scheduler state encoding.
package noc_pkg;

  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;

  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } sched_state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first eligible requester after rr_last, wrapping modulo NUM_REQ.
module rr_priority_picker
  import noc_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int IDX_W = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_last,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_last) + k) % NUM_REQ;
      if (!valid && eligible[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_output_scheduler.sv
// Per-output scheduler: round-robin header arbitration, then a crossbar lock held for the
// whole packet with one FIFO read pulse per forwarded flit while downstream is clear.
module packet_output_scheduler
  import noc_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int LEN_WIDTH = 12,
  localparam int IDX_W = idx_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [3*NUM_REQ-1:0]           req_flit_type,
  input  logic [LEN_WIDTH*NUM_REQ-1:0]   req_length,
  input  logic                           dcts,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             sel,
  output logic                           busy,
  output logic                           pkt_done,
  output logic                           len_err,
  output sched_state_e                   dbg_state
);

  // Handshake: a flit is consumed from FIFO i on every clk edge where grant[i]=1; grant
  // rises only while this port owns the lock, req[owner]=1 and dcts=1, with no further hold.

  sched_state_e         state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_last_q, rr_last_d;
  logic [NUM_REQ-1:0]   sel_q, sel_d;
  logic                 busy_q, busy_d;
  logic                 pkt_done_q, pkt_done_d;
  logic                 len_err_q, len_err_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [LEN_WIDTH-1:0] pick_len;
  logic [2:0]           own_type;
  logic                 last_flit;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req[i] && (req_flit_type[3*i +: 3] == FLIT_HEADER);
    end
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .eligible (eligible),
    .rr_last  (rr_last_q),
    .winner   (pick_onehot),
    .valid    (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    pick_len = '0;
    own_type = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) begin
        pick_idx = IDX_W'(i);
        pick_len = req_length[LEN_WIDTH*i +: LEN_WIDTH];
      end
      if (sel_q[i]) begin
        own_type = req_flit_type[3*i +: 3];
      end
    end
  end

  // Reset also masks grant so no flit leaves during the reset cycle itself.
  always_comb begin
    grant = '0;
    if ((state_q == SEND) && !rst) begin
      grant = sel_q & req & {NUM_REQ{dcts}};
    end
  end

  assign last_flit = (remaining_q == '0) || (own_type == FLIT_TAIL);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    sel_d       = sel_q;
    busy_d      = busy_q;
    pkt_done_d  = 1'b0;
    len_err_d   = len_err_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d     = SEND;
          owner_d     = pick_idx;
          sel_d       = pick_onehot;
          busy_d      = 1'b1;
          remaining_d = (pick_len == '0) ? '0 : pick_len - LEN_WIDTH'(1);
        end
      end
      SEND: begin
        if (|grant) begin
          if (last_flit) begin
            state_d    = IDLE;
            sel_d      = '0;
            busy_d     = 1'b0;
            rr_last_d  = owner_q;
            pkt_done_d = 1'b1;
            if (own_type != FLIT_TAIL) begin
              len_err_d = 1'b1;
            end
          end else begin
            remaining_d = remaining_q - LEN_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_last_q   <= IDX_W'(NUM_REQ - 1);
      sel_q       <= '0;
      busy_q      <= 1'b0;
      pkt_done_q  <= 1'b0;
      len_err_q   <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      pkt_done_q  <= pkt_done_d;
      len_err_q   <= len_err_d;
      remaining_q <= remaining_d;
    end
  end

  assign sel       = sel_q;
  assign busy      = busy_q;
  assign pkt_done  = pkt_done_q;
  assign len_err   = len_err_q;
  assign dbg_state = state_q;

endmodule
